// File: rtl/pdm_sample_feeder.sv
// Sample FIFO plus linear interpolator feeding the PDM modulator's level input.
// Samples are paced out once per STEP_CYCLES * 2^INTERP_LOG2 clocks.
module pdm_sample_feeder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int STEP_CYCLES = 16,
  parameter int INTERP_LOG2 = 7
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic signed [15:0]            sample_in,
  input  logic                          sample_valid_in,
  output logic                          sample_ready_out,
  output logic signed [15:0]            level_out,
  output logic [$clog2(FIFO_DEPTH):0]   fill_out,
  output logic                          underrun_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CYC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int K_W   = (INTERP_LOG2 > 0) ? INTERP_LOG2 : 1;
  localparam int ACC_W = 16 + INTERP_LOG2 + 2;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(STEP_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'((1 << INTERP_LOG2) - 1);

  // Arithmetic shift floors toward minus infinity, matching the ramp model.
  function automatic logic signed [15:0] floor_shift(input logic signed [ACC_W-1:0] a);
    return 16'(a >>> INTERP_LOG2);
  endfunction

  function automatic logic signed [16:0] diff17(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    return {a[15], a} - {b[15], b};
  endfunction

  logic signed [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [K_W-1:0]          k_q, k_d;
  logic signed [15:0]      next_q, next_d;
  logic signed [16:0]      delta_q, delta_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [15:0]      level_q, level_d;
  logic                    step_tick, boundary, push, pop;
  logic signed [15:0]      head;

  assign sample_ready_out = (fill_q < DEPTH_C);
  assign fill_out         = fill_q;
  assign level_out        = level_q;
  assign underrun_out     = boundary && (fill_q == '0);

  always_comb begin
    step_tick = (cyc_q == CYC_LAST);
    boundary  = step_tick && (k_q == K_LAST);
    push      = sample_valid_in && sample_ready_out;
    pop       = boundary && (fill_q != '0);
    head      = mem_q[rd_ptr_q];
    acc_sum   = acc_q + {{(ACC_W-17){delta_q[16]}}, delta_q};

    cyc_d    = step_tick ? '0 : cyc_q + CYC_W'(1);
    k_d      = k_q;
    acc_d    = acc_q;
    level_d  = level_q;
    next_d   = next_q;
    delta_d  = delta_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;

    if (step_tick) begin
      k_d     = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
      acc_d   = acc_sum;
      level_d = floor_shift(acc_sum);
    end

    // At a boundary acc already equals next << INTERP_LOG2, so the new
    // segment starts from the old target with a fresh slope.
    if (boundary) begin
      if (pop) begin
        next_d   = head;
        delta_d  = diff17(head, next_q);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        delta_d  = '0;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cyc_q    <= '0;
      k_q      <= '0;
      next_q   <= '0;
      delta_q  <= '0;
      acc_q    <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cyc_q    <= cyc_d;
      k_q      <= k_d;
      next_q   <= next_d;
      delta_q  <= delta_d;
      acc_q    <= acc_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Randomized bench for pdm_sample_feeder against a segment-based ramp model.
module tb_pdm_sample_feeder;
  localparam int D  = 4;
  localparam int S  = 4;
  localparam int L  = 2;
  localparam int N  = 1 << L;
  localparam int BP = S * N;

  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid_in = 1'b0;
  logic               sample_ready_out;
  logic signed [15:0] level_out;
  logic [2:0]         fill_out;
  logic               underrun_out;

  pdm_sample_feeder #(.FIFO_DEPTH(D), .STEP_CYCLES(S), .INTERP_LOG2(L)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_in(sample_in),
    .sample_valid_in(sample_valid_in), .sample_ready_out(sample_ready_out),
    .level_out(level_out), .fill_out(fill_out), .underrun_out(underrun_out)
  );

  always #5 clk_in = ~clk_in;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: FIFO as a queue, level as a straight line from m_from to m_to.
  int mq[$];
  int m_t, m_from, m_to, m_j, m_level;
  logic [20:0] obs_v, exp_v;

  function automatic int floordiv(input int a, input int n);
    int q;
    q = a / n;
    if ((a % n) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_t = 0; m_from = 0; m_to = 0; m_j = 0; m_level = 0;
  endtask

  function automatic logic [20:0] model_outputs();
    int sz;
    logic signed [15:0] lv;
    logic bnd;
    sz  = mq.size();
    lv  = 16'(m_level);
    bnd = ((m_t % BP) == BP - 1);
    return {lv, 3'(sz), (sz < D), (bnd && sz == 0)};
  endfunction

  task automatic model_edge(input logic v, input int d);
    int sz;
    sz = mq.size();
    if ((m_t % S) == S - 1) begin
      m_j++;
      m_level = floordiv(m_from * N + (m_to - m_from) * m_j, N);
    end
    if ((m_t % BP) == BP - 1) begin
      m_from = m_to;
      m_j = 0;
      if (sz > 0) m_to = mq.pop_front();
    end
    if (v && sz < D) mq.push_back(d);
    m_t++;
  endtask

  task automatic cycle(input logic v, input logic signed [15:0] d);
    sample_valid_in = v;
    sample_in = d;
    @(negedge clk_in);
    obs_v = {level_out, fill_out, sample_ready_out, underrun_out};
    exp_v = model_outputs();
    @(posedge clk_in);
    model_edge(v, int'(d));
    #1;
  endtask

  task automatic apply_reset();
    sample_valid_in = 1'b0;
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    sample_valid_in = 1'b1;
    sample_in = 16'sd1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      obs_v = {level_out, fill_out, sample_ready_out, underrun_out};
      tests_run++;
      if (obs_v !== {16'd0, 3'd0, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_hold cyc=%0d got %h want %h", i, obs_v, {16'd0, 3'd0, 1'b1, 1'b0});
      end
      @(posedge clk_in);
    end
    #1;
    rst_n_in = 1'b1;
    model_reset();
    cycle(1'b0, 16'sd0);
    tests_run++;
    if (obs_v !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_release got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_single_ramp();
    int unr;
    unr = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(i == 2, 16'sd1000);
      unr += int'(obs_v[0]);
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL single_ramp cyc=%0d got %h want %h", i, obs_v, exp_v);
      end
    end
    tests_run++;
    if (unr != 1) begin
      tests_failed++;
      $display("FAIL single_ramp_underruns got %0d want 1", unr);
    end
    tests_run++;
    if (level_out !== 16'sd1000) begin
      tests_failed++;
      $display("FAIL single_ramp_final got %0d want 1000", level_out);
    end
  endtask

  task automatic test_negative_floor();
    apply_reset();
    for (int i = 0; i < 36; i++) begin
      cycle(i == 0, -16'sd3);
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL neg_floor cyc=%0d got %h want %h", i, obs_v, exp_v);
      end
    end
    tests_run++;
    if (level_out !== -16'sd3) begin
      tests_failed++;
      $display("FAIL neg_floor_final got %0d want -3", level_out);
    end
  endtask

  task automatic test_extremes();
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      cycle(i < 2, (i == 0) ? 16'sh7fff : 16'sh8000);
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL extremes cyc=%0d got %h want %h", i, obs_v, exp_v);
      end
    end
    tests_run++;
    if (level_out !== 16'sh8000) begin
      tests_failed++;
      $display("FAIL extremes_final got %0d want -32768", level_out);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] arr [6];
    int idx, max_fill, fifth_cyc;
    logic v;
    for (int i = 0; i < 6; i++) arr[i] = 16'($urandom);
    idx = 0; max_fill = 0; fifth_cyc = -1;
    apply_reset();
    for (int i = 0; i < 120; i++) begin
      v = (idx < 5);
      cycle(v, arr[idx]);
      if (v && obs_v[1]) begin
        if (idx == 4) fifth_cyc = i;
        idx++;
      end
      if (int'(obs_v[4:2]) > max_fill) max_fill = int'(obs_v[4:2]);
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL back_to_back cyc=%0d got %h want %h", i, obs_v, exp_v);
      end
    end
    tests_run++;
    if (max_fill != 4) begin
      tests_failed++;
      $display("FAIL b2b_max_fill got %0d want 4", max_fill);
    end
    tests_run++;
    if (fifth_cyc != BP) begin
      tests_failed++;
      $display("FAIL b2b_fifth_accept got %0d want %0d", fifth_cyc, BP);
    end
    tests_run++;
    if (level_out !== arr[4]) begin
      tests_failed++;
      $display("FAIL b2b_final got %0d want %0d", level_out, arr[4]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 7) == 0, 16'($urandom));
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      cycle(i < 2, (i == 0) ? 16'sd20000 : 16'sd100);
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL async_pre cyc=%0d got %h want %h", i, obs_v, exp_v);
      end
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    tests_run++;
    if ({level_out, fill_out, sample_ready_out} !== {16'd0, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL async_immediate got lvl=%0d fill=%0d rdy=%0b want 0 0 1",
               level_out, fill_out, sample_ready_out);
    end
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    model_reset();
    for (int i = 0; i < 36; i++) begin
      cycle(i == 0, 16'sd400);
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL async_post cyc=%0d got %h want %h", i, obs_v, exp_v);
      end
    end
    tests_run++;
    if (level_out !== 16'sd400) begin
      tests_failed++;
      $display("FAIL async_post_final got %0d want 400", level_out);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_ramp();
    test_negative_floor();
    test_extremes();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
